// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among N requesters, with locked bursts
module uart_tx_arbiter #(
  parameter int N = 4,
  parameter int WL = 8,
  parameter int START_TIMEOUT = 16,
  parameter int HOLD_MAX = 1024
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         req,
  input  logic [N*WL-1:0]      req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         ack,
  output logic                 tx_start,
  output logic [WL-1:0]        tx_data,
  input  logic                 tx_busy,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 start_err,
  output logic                 hold_err
);
  localparam int IW = $clog2(N);
  localparam int SW = START_TIMEOUT > 1 ? $clog2(START_TIMEOUT) : 1;
  localparam int HW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, HOLD} state_t;
  state_t state, state_n;
  logic [IW-1:0] ptr, ptr_n, gid_n, pick;
  logic gv_n, lock, lock_n, serr_n, herr_n, rel;
  logic [SW-1:0] scnt, scnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [WL-1:0] data_q;
  // descending scan so the requester closest to ptr wins
  always_comb begin
    pick = ptr;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) pick = IW'((int'(ptr) + i) % N);
  end
  assign tx_start = state == ISSUE;
  assign ack = tx_start ? N'(1) << grant_id : '0;
  assign tx_data = tx_start ? req_data[grant_id*WL +: WL] : data_q;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    gid_n = grant_id;
    gv_n = grant_valid;
    lock_n = lock;
    scnt_n = scnt;
    hcnt_n = hcnt;
    serr_n = start_err;
    herr_n = hold_err;
    rel = 1'b0;
    case (state)
      IDLE:
        if (|req) begin
          gid_n = pick;
          gv_n = 1'b1;
          state_n = ISSUE;
        end
      ISSUE: begin
        lock_n = ~req_last[grant_id];
        scnt_n = '0;
        state_n = WAIT_START;
      end
      WAIT_START:
        if (tx_busy) state_n = WAIT_DONE;
        else if (scnt == SW'(START_TIMEOUT - 1)) begin
          serr_n = 1'b1;
          rel = 1'b1;
        end else scnt_n = scnt + 1'b1;
      WAIT_DONE:
        if (!tx_busy) begin
          if (!lock) rel = 1'b1;
          else if (req[grant_id]) state_n = ISSUE;
          else begin
            hcnt_n = '0;
            state_n = HOLD;
          end
        end
      HOLD:
        if (req[grant_id]) state_n = ISSUE;
        else if (hcnt == HW'(HOLD_MAX - 1)) begin
          herr_n = 1'b1;
          rel = 1'b1;
        end else hcnt_n = hcnt + 1'b1;
      default: state_n = IDLE;
    endcase
    // every exit from ownership funnels through here
    if (rel) begin
      ptr_n = grant_id == IW'(N - 1) ? '0 : grant_id + 1'b1;
      gv_n = 1'b0;
      lock_n = 1'b0;
      state_n = IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr <= '0;
      grant_id <= '0;
      grant_valid <= 1'b0;
      lock <= 1'b0;
      scnt <= '0;
      hcnt <= '0;
      start_err <= 1'b0;
      hold_err <= 1'b0;
      data_q <= '0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      grant_id <= gid_n;
      grant_valid <= gv_n;
      lock <= lock_n;
      scnt <= scnt_n;
      hcnt <= hcnt_n;
      start_err <= serr_n;
      hold_err <= herr_n;
      data_q <= tx_data;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic checked against a sequential reference model
module tb_uart_tx_arbiter;
  localparam int N = 4, WL = 8, ST = 16, HM = 8, IW = $clog2(N);
  logic clk = 0, rst = 1, tx_busy = 0;
  logic [N-1:0] req = '0, req_last = '0;
  logic [N*WL-1:0] req_data = '0;
  logic [N-1:0] ack;
  logic tx_start, grant_valid, start_err, hold_err;
  logic [WL-1:0] tx_data;
  logic [IW-1:0] grant_id;
  int npass = 0, ntot = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.N(N), .WL(WL), .START_TIMEOUT(ST), .HOLD_MAX(HM)) dut (
    .CLK(clk), .RST(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_valid(grant_valid), .grant_id(grant_id), .start_err(start_err), .hold_err(hold_err)
  );
  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endfunction
  function automatic void fail(string nm);
    ntot++;
    $display("FAIL %s: got no event, want one within bound", nm);
  endfunction
  // reference model: one byte transaction at a time, expressed as a sequential program
  logic [N-1:0] e_ack;
  logic e_start, e_gv, e_serr, e_herr;
  logic [WL-1:0] e_data;
  logic [IW-1:0] e_gid;
  int m_ptr;
  bit abort;
  task automatic step();
    @(posedge clk);
    abort = rst;
  endtask
  task automatic m_reset();
    e_ack = '0; e_start = 0; e_gv = 0; e_gid = '0; e_serr = 0; e_herr = 0; e_data = '0; m_ptr = 0;
  endtask
  task automatic m_release(int o);
    m_ptr = (o + 1) % N;
    e_gv = 0;
  endtask
  task automatic run();
    int o;
    bit ok, last;
    forever begin
      step();
      if (abort) return;
      if (req == '0) continue;
      o = -1;
      for (int k = 0; k < N; k++) if (o < 0 && req[(m_ptr + k) % N]) o = (m_ptr + k) % N;
      e_gv = 1;
      e_gid = IW'(o);
      forever begin
        e_start = 1;
        e_ack = N'(1) << o;
        e_data = req_data[o*WL +: WL];
        last = req_last[o];
        step();
        if (abort) return;
        e_start = 0;
        e_ack = '0;
        ok = 0;
        for (int k = 0; k < ST && !ok; k++) begin
          step();
          if (abort) return;
          ok = tx_busy;
        end
        if (!ok) begin e_serr = 1; m_release(o); break; end
        do begin
          step();
          if (abort) return;
        end while (tx_busy);
        if (last) begin m_release(o); break; end
        if (!req[o]) begin
          ok = 0;
          for (int k = 0; k < HM && !ok; k++) begin
            step();
            if (abort) return;
            ok = req[o];
          end
          if (!ok) begin e_herr = 1; m_release(o); break; end
        end
      end
    end
  endtask
  initial forever begin
    m_reset();
    run();
  end
  always @(negedge clk) if (chk_en) begin
    check("ack", ack, e_ack);
    check("tx_start", tx_start, e_start);
    check("tx_data", tx_data, e_data);
    check("grant_valid", grant_valid, e_gv);
    if (e_gv) check("grant_id", grant_id, e_gid);
    check("start_err", start_err, e_serr);
    check("hold_err", hold_err, e_herr);
    if (tx_start) check("start_while_busy", tx_busy, 1'b0);
  end
  // stimulus: serializer and requesters advanced in one process, 1 time unit after each edge
  logic [N-1:0] s_ack;
  logic s_start, s_gv, s_serr, s_herr;
  logic [WL-1:0] s_data;
  logic [IW-1:0] s_gid;
  bit ser_pend = 0, no_resp = 0, rnd_mode = 0;
  int ser_dly, ser_hold, dmin = 0, dmax = 0, hmin = 1, hmax = 1;
  int pend[N], gap[N], left[N];
  function automatic int burst_gap();
    int r = int'($urandom_range(0, 9));
    return r < 6 ? 0 : r < 8 ? int'($urandom_range(2, 6)) : int'($urandom_range(9, 12));
  endfunction
  task automatic rnd_req();
    for (int i = 0; i < N; i++) begin
      if (rst) begin pend[i] = 0; gap[i] = 0; left[i] = 0; end
      else begin
        if (s_ack[i]) begin
          pend[i] = 0;
          left[i]--;
          gap[i] = left[i] > 0 ? burst_gap() : int'($urandom_range(0, 6));
        end
        if (pend[i] == 0) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            if (left[i] <= 0) left[i] = int'($urandom_range(1, 3));
            pend[i] = 1;
            req_data[i*WL +: WL] = WL'($urandom);
            req_last[i] = left[i] == 1;
          end
        end
      end
      req[i] = pend[i] != 0;
    end
  endtask
  task automatic tick();
    @(negedge clk);
    s_ack = ack; s_start = tx_start; s_data = tx_data; s_gv = grant_valid;
    s_gid = grant_id; s_serr = start_err; s_herr = hold_err;
    @(posedge clk);
    #1;
    if (rst) begin tx_busy = 0; ser_pend = 0; end
    else begin
      if (s_start && !no_resp) begin ser_pend = 1; ser_dly = int'($urandom_range(dmin, dmax)); end
      if (ser_pend) begin
        if (ser_dly == 0) begin
          ser_pend = 0;
          tx_busy = 1;
          ser_hold = int'($urandom_range(hmin, hmax)) - 1;
        end else ser_dly--;
      end else if (tx_busy) begin
        if (ser_hold == 0) tx_busy = 0;
        else ser_hold--;
      end
    end
    if (rnd_mode) rnd_req();
  endtask
  task automatic do_reset();
    rst = 1;
    req = '0;
    req_last = '0;
    tick();
    tick();
    rst = 0;
  endtask
  task automatic wait_ack(output int id, output int d);
    id = -1;
    d = 0;
    for (int k = 0; k < 300 && id < 0; k++) begin
      tick();
      for (int j = 0; j < N; j++) if (s_ack[j]) id = j;
    end
    if (id < 0) fail("ack_timeout");
    else begin
      check("ack_onehot", $countones(s_ack), 1);
      d = s_data;
    end
  endtask
  initial begin
    int id, d, n;
    int ord[5] = '{1, 1, 1, 3, 0};
    // single byte to requester 2
    do_reset();
    chk_en = 1;
    check("reset_outputs", {s_ack, s_start, s_gv, s_gid, s_serr, s_herr, s_data}, 0);
    dmin = 0; dmax = 0; hmin = 40; hmax = 40;
    req[2] = 1; req_data[23:16] = 8'h5A; req_last[2] = 1;
    tick();
    check("single_no_early_start", s_start, 0);
    tick();
    check("single_start", s_start, 1);
    check("single_data", s_data, 8'h5A);
    check("single_ack", s_ack, 4'b0100);
    check("single_gid", s_gid, 2);
    req[2] = 0;
    n = 0;
    do begin tick(); n++; end while (s_gv && n < 100);
    check("single_gv_fall_cycle", n, 42);
    hmin = 1; hmax = 3;
    req = 4'b1011; req_last = 4'b1111;
    wait_ack(id, d);
    check("single_next_ptr", id, 3);
    // fairness with persistent requests
    do_reset();
    dmin = 0; dmax = 2; hmin = 2; hmax = 4;
    req = 4'b1111; req_last = 4'b1111;
    for (int a = 0; a < 5; a++) begin
      wait_ack(id, d);
      check("fair_order", id, a % N);
      if (id >= 0) req_data[id*WL +: WL] = WL'($urandom);
    end
    // locked burst from requester 1 against 0 and 3
    do_reset();
    dmin = 0; dmax = 1; hmin = 2; hmax = 3;
    req = 4'b0001; req_last = 4'b0001;
    wait_ack(id, d);
    check("burst_pre", id, 0);
    req = 4'b1011; req_last = 4'b1001; req_data[15:8] = 8'h10;
    for (int a = 0; a < 5; a++) begin
      wait_ack(id, d);
      check("burst_order", id, ord[a]);
      if (a < 3) check("burst_data", d, 32'h10 + a);
      if (a == 0) req_data[15:8] = 8'h11;
      else if (a == 1) begin req_data[15:8] = 8'h12; req_last[1] = 1; end
      else if (id >= 0) req[id] = 0;
    end
    // hold gap resumed, then a gap long enough to break the lock
    do_reset();
    dmin = 0; dmax = 0; hmin = 3; hmax = 3;
    req = 4'b0010; req_last = 4'b0000; req_data[15:8] = 8'h21;
    wait_ack(id, d);
    check("hold_first", id, 1);
    req[1] = 0; req[2] = 1; req_last[2] = 1;
    n = 0;
    for (int k = 0; k < 9; k++) begin tick(); if (s_ack != '0) n++; end
    check("hold_blocks_others", n, 0);
    req[1] = 1; req_data[15:8] = 8'h22;
    wait_ack(id, d);
    check("hold_resume_id", id, 1);
    check("hold_resume_data", d, 8'h22);
    check("hold_err_clear", s_herr, 0);
    req[1] = 0;
    n = 0;
    do begin tick(); n++; end while (!s_herr && n < 100);
    check("hold_err_cycle", n, 13);
    wait_ack(id, d);
    check("hold_next_owner", id, 2);
    // start timeout with a silent serializer
    do_reset();
    no_resp = 1;
    req = 4'b0011; req_last = 4'b0011;
    wait_ack(id, d);
    check("timeout_first", id, 0);
    req[0] = 0;
    n = 0;
    do begin tick(); n++; end while (!s_serr && n < 100);
    check("timeout_cycle", n, 17);
    check("timeout_release", s_gv, 0);
    wait_ack(id, d);
    check("timeout_next", id, 1);
    check("timeout_sticky", s_serr, 1);
    no_resp = 0;
    // reset in the middle of a locked burst
    do_reset();
    dmin = 0; dmax = 0; hmin = 10; hmax = 10;
    req = 4'b0001; req_last = 4'b0000;
    wait_ack(id, d);
    check("rstmid_first", id, 0);
    repeat (4) tick();
    rst = 1;
    tick();
    rst = 0;
    req = 4'b1010; req_last = 4'b1010;
    tick();
    check("rstmid_outputs", {s_ack, s_start, s_gv, s_gid, s_serr, s_herr, s_data}, 0);
    wait_ack(id, d);
    check("rstmid_next", id, 1);
    // randomized traffic
    do_reset();
    dmin = 0; dmax = 3; hmin = 1; hmax = 6;
    rnd_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) no_resp = $urandom_range(0, 5) == 0;
      if (c % 900 == 899) begin
        rst = 1;
        tick();
        tick();
        rst = 0;
      end else tick();
    end
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter among N byte-producing requesters (command responder, status reporter, debug echo, etc.).
- Sequences the transmitter start/busy handshake, one byte at a time.
- Supports locked bursts: an owner keeps the transmitter until it flags its last byte, so multi-byte messages are never interleaved.
- Sits between the requesters and the UART TX serializer, as the transmit-side counterpart of the UART receiver.

Parameters:
- N, 4, number of requesters (2..8).
- WL, 8, data word length; must match the serializer.
- START_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before aborting.
- HOLD_MAX, 1024, cycles a locked owner may leave req low between burst bytes before the lock is forcibly released.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- req  in  N  per-requester byte-pending; held until ack.
- req_data  in  N*WL  per-requester byte; requester i occupies bits [i*WL +: WL].
- req_last  in  N  byte is the final byte of the requester's burst; 1 means a single-byte message.
- ack  out  N  one-cycle pulse: byte of requester i is taken; requester may change data next cycle.
- tx_start  out  1  one-cycle start pulse to the serializer.
- tx_data  out  WL  byte to the serializer; valid while tx_start=1 and held until the next start.
- tx_busy  in  1  serializer busy; rises by START_TIMEOUT cycles after tx_start and falls at the end of the stop bit.
- grant_valid  out  1  an owner holds the transmitter.
- grant_id  out  $clog2(N)  current owner index.
- start_err  out  1  sticky: tx_busy never rose; cleared by RST only.
- hold_err  out  1  sticky: lock released by HOLD_MAX; cleared by RST only.

Behaviour:
- Reset values:
  - all outputs 0;
  - state IDLE;
  - round-robin pointer 0 (requester 0 has first priority);
  - lock 0; counters 0.
- Reset mid-transfer aborts immediately: no ack or tx_start is issued, and any byte the serializer is sending is not tracked.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, HOLD.
- IDLE:
  - If any req is high, select the first requester with req high, scanning from ptr, ptr+1, ... wrapping mod N.
  - Register grant_id and set grant_valid=1, then go to ISSUE.
  - Selection and issue occupy separate cycles, so req→tx_start latency is 2 cycles.
- ISSUE (1 cycle):
  - tx_start=1, tx_data=req_data[grant_id], ack[grant_id]=1.
  - Latch lock = ~req_last[grant_id].
  - Clear the start counter and go to WAIT_START.
- WAIT_START:
  - If tx_busy=1, go to WAIT_DONE.
  - Otherwise increment the counter; when it reaches START_TIMEOUT-1, set start_err=1, release the grant and go to IDLE.
  - tx_busy already high in the first WAIT_START cycle counts as accepted.
- WAIT_DONE:
  - On tx_busy=0: if lock=0, release; if lock=1 and req[grant_id]=1, go to ISSUE (same owner, no re-arbitration); if lock=1 and req low, go to HOLD with the hold counter cleared.
- HOLD:
  - req[grant_id]=1 → ISSUE.
  - Otherwise count; at HOLD_MAX-1 set hold_err=1 and release.
  - Other requesters stay blocked throughout HOLD.
- Release (single rule for every exit):
  - ptr = (grant_id+1) mod N, grant_valid=0, lock=0, next state IDLE.
  - The same cycle's IDLE decision uses the updated ptr, one cycle later.
- A requester dropping req without ack is legal and is simply not selected. ack is only issued to the current owner.
- Simultaneous requests are resolved purely by ptr order; no requester waits more than N-1 bursts.
- ptr wraps from N-1 to 0.
- Counters are sized to $clog2 of their maximum and must not overflow.

Test Plan:
- Single byte: N=4; req[2]=1, data 0x5A, last=1; serializer raises busy 1 cycle after start and holds it 40 cycles → tx_start 2 cycles after req, tx_data=0x5A, ack[2] pulse in the same cycle, grant_id=2, grant_valid falls when busy falls, next ptr=3.
- Fairness: req=4'b1111, all last=1, persistent → grant order 0,1,2,3,0; exactly one ack per byte; no tx_start while tx_busy=1.
- Burst lock: req[1] sends 0x10,0x11,0x12 with last only on 0x12 while req[0] and req[3] are high → three consecutive 1 grants, then 3 is served before 0.
- HOLD: req[1] sends a locked byte then drops req for 5 cycles → no other grant during the gap, resumes on req[1]. The same gap with HOLD_MAX=8 extended to 20 cycles → hold_err=1, lock released, next owner 2 (or 3/0 per req).
- Start timeout: tx_busy tied 0 → after START_TIMEOUT cycles start_err=1, grant released, next requester is served, start_err stays 1.
- Reset mid-burst: RST during WAIT_DONE of a locked burst → next cycle all outputs 0 and ptr=0; with req=4'b1010 after reset, requester 1 is granted first.
